// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment display bus: scanned digit enables/segments in,
// decoded frame and status pulses out.
interface seg7_scan_decoder_if;
  logic [3:0]  an;
  logic [0:6]  seg;
  logic [15:0] value;
  logic        frame_valid;
  logic        pat_err;
  logic        seq_err;

  modport master (
    output an, seg,
    input  value, frame_valid, pat_err, seq_err
  );

  modport slave (
    input  an, seg,
    output value, frame_valid, pat_err, seq_err
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the 4-digit hex value shown on a scanned, active-low 7-segment
// display by watching its digit enables and segment lines.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYC = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seg7_scan_decoder_if.slave  bus
);
  localparam int unsigned AN_W  = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned VAL_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [AN_W-1:0]  AN_NONE = 4'b1111;
  localparam logic [AN_W-1:0]  AN_DIG0 = 4'b1110;

  typedef enum logic [1:0] {SYNC, SETTLE, HOLD} state_t;

  state_t            state, state_n;
  logic [AN_W-1:0]   an_s1, an_s2, an_p;
  logic [0:SEG_W-1]  seg_s1, seg_s2, seg_p;
  logic [1:0]        idx, idx_n, idx_inc;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [3:0][3:0]   slot, slot_n;
  logic [3:0]        err, err_n;
  logic [VAL_W-1:0]  value_q, value_n;
  logic              frame_valid_q, frame_valid_n;
  logic              pat_err_q, pat_err_n;
  logic              seq_err_q, seq_err_n;
  logic [4:0]        dec;
  logic [AN_W-1:0]   an_exp, an_nxt;
  logic              same;

  // {pattern_error, nibble} for an active-low g..a segment pattern
  function automatic logic [4:0] decode(input logic [0:6] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  // Two-flop synchronizer plus one-sample history for the stability check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1  <= AN_NONE;
      an_s2  <= AN_NONE;
      an_p   <= AN_NONE;
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_p  <= '1;
    end else begin
      an_s1  <= bus.an;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= bus.seg;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  // State register with frame datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SYNC;
      idx           <= '0;
      cnt           <= '0;
      slot          <= '0;
      err           <= '0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      pat_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      cnt           <= cnt_n;
      slot          <= slot_n;
      err           <= err_n;
      value_q       <= value_n;
      frame_valid_q <= frame_valid_n;
      pat_err_q     <= pat_err_n;
      seq_err_q     <= seq_err_n;
    end
  end

  // Next-state: scan tracking, digit settling and frame assembly
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    cnt_n         = cnt;
    slot_n        = slot;
    err_n         = err;
    value_n       = value_q;
    frame_valid_n = 1'b0;
    pat_err_n     = 1'b0;
    seq_err_n     = 1'b0;
    dec           = decode(seg_s2);
    idx_inc       = idx + 2'd1;
    an_exp        = ~(AN_W'(1) << idx);
    an_nxt        = ~(AN_W'(1) << idx_inc);
    same          = ({an_s2, seg_s2} == {an_p, seg_p});

    case (state)
      SYNC: begin
        // The sample that reveals digit 0 is the first of its stable run
        if (an_s2 == AN_DIG0) begin
          state_n = SETTLE;
          idx_n   = 2'd0;
          cnt_n   = CNT_W'(1);
          err_n   = '0;
        end
      end
      SETTLE: begin
        if (an_s2 == AN_NONE) begin
          cnt_n = '0;
        end else if (an_s2 != an_exp) begin
          seq_err_n = 1'b1;
          state_n   = SYNC;
          cnt_n     = '0;
          err_n     = '0;
        end else begin
          if (!same)               cnt_n = CNT_W'(1);
          else if (cnt >= CNT_MAX) cnt_n = CNT_MAX;
          else                     cnt_n = cnt + CNT_W'(1);
          if (cnt_n == CNT_MAX) begin
            state_n     = HOLD;
            slot_n[idx] = dec[3:0];
            err_n[idx]  = dec[4];
            if (idx == 2'd3) begin
              value_n       = {dec[3:0], slot[2], slot[1], slot[0]};
              frame_valid_n = 1'b1;
              pat_err_n     = (|err[2:0]) | dec[4];
              err_n         = '0;
            end
          end
        end
      end
      HOLD: begin
        if (an_s2 == an_exp || an_s2 == AN_NONE) begin
          state_n = HOLD;
        end else if (an_s2 == an_nxt) begin
          state_n = SETTLE;
          idx_n   = idx_inc;
          cnt_n   = CNT_W'(1);
        end else begin
          seq_err_n = 1'b1;
          state_n   = SYNC;
          cnt_n     = '0;
          err_n     = '0;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  assign bus.value       = value_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.pat_err     = pat_err_q;
  assign bus.seq_err     = seq_err_q;
endmodule
